// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit compressed trace symbols LSB-first into DCT words and hands them
// to the trace sink over valid/ready; flushes the partial word on end request.
module nios2_oci_dct_packer #(
   parameter int SYM_W = 2,
   parameter int SLOTS = 15,
   parameter int CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sym_valid,
   input  logic [SYM_W-1:0]         sym_data,
   output logic                     sym_ready,
   input  logic                     end_req,
   output logic                     dct_valid,
   input  logic                     dct_ready,
   output logic [SYM_W*SLOTS-1:0]   dct_buffer,
   output logic [CNT_W-1:0]         dct_count,
   output logic                     test_ending,
   output logic                     test_has_ended
);

   localparam int               BUF_W = SYM_W * SLOTS;
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(SLOTS);

   typedef enum logic [1:0] {
      RUN,
      ENDING,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [BUF_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   accCnt_q, accCnt_d;
   logic [BUF_W-1:0]   outBuf_q, outBuf_d;
   logic [CNT_W-1:0]   outCnt_q, outCnt_d;
   logic               outValid_q, outValid_d;

   logic outFree;
   logic accFull;
   logic doTransfer;
   logic doAccept;

   assign accFull        = (accCnt_q == FULL);
   assign outFree        = !outValid_q || dct_ready;
   assign sym_ready      = (state_q == RUN) && !accFull;
   assign doAccept       = sym_valid && sym_ready;
   assign doTransfer     = outFree && (accFull || ((state_q == ENDING) && (accCnt_q != '0)));

   assign dct_valid      = outValid_q;
   assign dct_buffer     = outBuf_q;
   assign dct_count      = outCnt_q;
   assign test_ending    = (state_q != RUN);
   assign test_has_ended = (state_q == DONE);

   // Accept and transfer are mutually exclusive because sym_ready is low
   // whenever a transfer could fire.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      accCnt_d   = accCnt_q;
      outBuf_d   = outBuf_q;
      outCnt_d   = outCnt_q;
      outValid_d = outValid_q;

      if (doTransfer) begin
         outBuf_d   = acc_q;
         outCnt_d   = accCnt_q;
         outValid_d = 1'b1;
         acc_d      = '0;
         accCnt_d   = '0;
      end else begin
         if (doAccept) begin
            for (int k = 0; k < SLOTS; k++) begin
               if (accCnt_q == CNT_W'(k)) begin
                  acc_d[k*SYM_W +: SYM_W] = sym_data;
               end
            end
            accCnt_d = accCnt_q + CNT_W'(1);
         end
         if (outValid_q && dct_ready) begin
            outValid_d = 1'b0;
         end
      end

      case (state_q)
         RUN: begin
            if (end_req) begin
               state_d = ENDING;
            end
         end
         ENDING: begin
            if ((accCnt_q == '0) && outFree) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         acc_q      <= '0;
         accCnt_q   <= '0;
         outBuf_q   <= '0;
         outCnt_q   <= '0;
         outValid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         accCnt_q   <= accCnt_d;
         outBuf_q   <= outBuf_d;
         outCnt_q   <= outCnt_d;
         outValid_q <= outValid_d;
      end
   end

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Directed bench for the DCT packer: full word, backpressure, partial flush,
// empty end, simultaneous symbol/end and mid-word reset.
module tb_nios2_oci_dct_packer;

   logic        clk;
   logic        reset;
   logic        sym_valid;
   logic [1:0]  sym_data;
   logic        sym_ready;
   logic        end_req;
   logic        dct_valid;
   logic        dct_ready;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_ending;
   logic        test_has_ended;

   int checks;
   int errors;

   nios2_oci_dct_packer dut (
      .clk            (clk),
      .reset          (reset),
      .sym_valid      (sym_valid),
      .sym_data       (sym_data),
      .sym_ready      (sym_ready),
      .end_req        (end_req),
      .dct_valid      (dct_valid),
      .dct_ready      (dct_ready),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [1:0] data, input logic endReq);
      sym_valid = valid;
      sym_data  = data;
      end_req   = endReq;
      tick();
   endtask

   task automatic applyReset();
      reset     = 1'b1;
      sym_valid = 1'b0;
      sym_data  = 2'b00;
      end_req   = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // Symbol sequence for the backpressure run; irregular so loss or duplication shows.
   function automatic logic [1:0] seqSym(input int i);
      logic [1:0] s;
      s = 2'((i * 7 + i / 5) % 4);
      return s;
   endfunction

   function automatic logic [29:0] packWord(input int first, input int n);
      logic [29:0] w;
      w = '0;
      for (int k = 0; k < n; k++) begin
         w[2*k +: 2] = seqSym(first + k);
      end
      return w;
   endfunction

   initial begin
      int          accepts;
      int          nWords;
      int          readyLow;
      logic [29:0] gotBuf [4];
      logic [3:0]  gotCnt [4];

      checks    = 0;
      errors    = 0;
      dct_ready = 1'b1;
      $display("[TB] start");

      // Reset values.
      applyReset();
      checkOutput("rst_valid", 32'(dct_valid), 32'd0);
      checkOutput("rst_buffer", 32'(dct_buffer), 32'd0);
      checkOutput("rst_count", 32'(dct_count), 32'd0);
      checkOutput("rst_ending", 32'(test_ending), 32'd0);
      checkOutput("rst_ended", 32'(test_has_ended), 32'd0);
      checkOutput("rst_ready", 32'(sym_ready), 32'd1);

      // Full word, slot k = k mod 4.
      readyLow = 0;
      for (int k = 0; k < 15; k++) begin
         if (!sym_ready) readyLow++;
         applyStimulus(1'b1, 2'(k % 4), 1'b0);
      end
      checkOutput("full_ready_before", 32'(readyLow), 32'd0);
      checkOutput("full_bubble_ready", 32'(sym_ready), 32'd0);
      checkOutput("full_bubble_valid", 32'(dct_valid), 32'd0);
      applyStimulus(1'b0, 2'b00, 1'b0);
      checkOutput("full_valid", 32'(dct_valid), 32'd1);
      checkOutput("full_buffer", 32'(dct_buffer), 32'h24E4E4E4);
      checkOutput("full_count", 32'(dct_count), 32'd15);
      checkOutput("full_ready_again", 32'(sym_ready), 32'd1);
      tick();
      checkOutput("full_drained", 32'(dct_valid), 32'd0);

      // Backpressure: sink stalled while 40 cycles of symbols are offered.
      dct_ready = 1'b0;
      accepts   = 0;
      for (int c = 0; c < 40; c++) begin
         sym_valid = 1'b1;
         sym_data  = seqSym(accepts);
         if (sym_ready) accepts++;
         tick();
      end
      checkOutput("bp_accepts", 32'(accepts), 32'd30);
      checkOutput("bp_ready_low", 32'(sym_ready), 32'd0);
      checkOutput("bp_valid_held", 32'(dct_valid), 32'd1);
      checkOutput("bp_buffer_held", 32'(dct_buffer), 32'(packWord(0, 15)));
      checkOutput("bp_count_held", 32'(dct_count), 32'd15);

      dct_ready = 1'b1;
      nWords    = 0;
      for (int c = 0; c < 80; c++) begin
         if (test_has_ended) break;
         if (accepts < 40) begin
            sym_valid = 1'b1;
            sym_data  = seqSym(accepts);
         end else begin
            sym_valid = 1'b0;
            end_req   = 1'b1;
         end
         if (dct_valid && dct_ready) begin
            if (nWords < 4) begin
               gotBuf[nWords] = dct_buffer;
               gotCnt[nWords] = dct_count;
            end
            nWords++;
         end
         if (sym_valid && sym_ready) accepts++;
         tick();
      end
      checkOutput("bp_done", 32'(test_has_ended), 32'd1);
      checkOutput("bp_total_accepts", 32'(accepts), 32'd40);
      checkOutput("bp_words", 32'(nWords), 32'd3);
      if (nWords >= 3) begin
         checkOutput("bp_w0_buf", 32'(gotBuf[0]), 32'(packWord(0, 15)));
         checkOutput("bp_w0_cnt", 32'(gotCnt[0]), 32'd15);
         checkOutput("bp_w1_buf", 32'(gotBuf[1]), 32'(packWord(15, 15)));
         checkOutput("bp_w1_cnt", 32'(gotCnt[1]), 32'd15);
         checkOutput("bp_w2_buf", 32'(gotBuf[2]), 32'(packWord(30, 10)));
         checkOutput("bp_w2_cnt", 32'(gotCnt[2]), 32'd10);
      end

      // Partial flush of five 2'b11 symbols.
      applyReset();
      for (int k = 0; k < 5; k++) applyStimulus(1'b1, 2'b11, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b1);
      end_req = 1'b0;
      checkOutput("pf_ending", 32'(test_ending), 32'd1);
      checkOutput("pf_ready0", 32'(sym_ready), 32'd0);
      checkOutput("pf_not_ended", 32'(test_has_ended), 32'd0);
      tick();
      checkOutput("pf_valid", 32'(dct_valid), 32'd1);
      checkOutput("pf_buffer", 32'(dct_buffer), 32'h000003FF);
      checkOutput("pf_count", 32'(dct_count), 32'd5);
      checkOutput("pf_not_ended2", 32'(test_has_ended), 32'd0);
      checkOutput("pf_ready1", 32'(sym_ready), 32'd0);
      tick();
      checkOutput("pf_drained", 32'(dct_valid), 32'd0);
      checkOutput("pf_ended", 32'(test_has_ended), 32'd1);
      checkOutput("pf_ready2", 32'(sym_ready), 32'd0);

      // Empty end: nothing buffered.
      applyReset();
      applyStimulus(1'b0, 2'b00, 1'b1);
      checkOutput("ee_ending", 32'(test_ending), 32'd1);
      checkOutput("ee_not_ended", 32'(test_has_ended), 32'd0);
      applyStimulus(1'b0, 2'b00, 1'b0);
      checkOutput("ee_ended", 32'(test_has_ended), 32'd1);
      checkOutput("ee_no_valid", 32'(dct_valid), 32'd0);
      applyStimulus(1'b0, 2'b00, 1'b1);
      applyStimulus(1'b0, 2'b00, 1'b0);
      checkOutput("ee_sticky", 32'(test_has_ended), 32'd1);
      checkOutput("ee_still_no_valid", 32'(dct_valid), 32'd0);

      // Symbol and end request in the same cycle.
      applyReset();
      applyStimulus(1'b1, 2'b01, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b0);
      applyStimulus(1'b1, 2'b10, 1'b1);
      sym_valid = 1'b0;
      end_req   = 1'b0;
      checkOutput("sim_ending", 32'(test_ending), 32'd1);
      tick();
      checkOutput("sim_valid", 32'(dct_valid), 32'd1);
      checkOutput("sim_buffer", 32'(dct_buffer), 32'h25);
      checkOutput("sim_count", 32'(dct_count), 32'd3);
      tick();
      checkOutput("sim_ended", 32'(test_has_ended), 32'd1);

      // Reset in the middle of a word.
      applyReset();
      for (int k = 0; k < 7; k++) applyStimulus(1'b1, 2'b11, 1'b0);
      applyReset();
      checkOutput("mr_valid", 32'(dct_valid), 32'd0);
      checkOutput("mr_buffer", 32'(dct_buffer), 32'd0);
      checkOutput("mr_count", 32'(dct_count), 32'd0);
      checkOutput("mr_ending", 32'(test_ending), 32'd0);
      checkOutput("mr_ready", 32'(sym_ready), 32'd1);
      readyLow = 0;
      for (int k = 0; k < 15; k++) begin
         if (!sym_ready) readyLow++;
         applyStimulus(1'b1, 2'(k % 4), 1'b0);
      end
      checkOutput("mr_ready_burst", 32'(readyLow), 32'd0);
      checkOutput("mr_no_early_word", 32'(dct_valid), 32'd0);
      applyStimulus(1'b0, 2'b00, 1'b0);
      checkOutput("mr_word_valid", 32'(dct_valid), 32'd1);
      checkOutput("mr_word_buffer", 32'(dct_buffer), 32'h24E4E4E4);
      checkOutput("mr_word_count", 32'(dct_count), 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
